// File: rtl/coffee_pkg.sv
// Shared step codes, recipe record layout and the built-in recipe table for the coffee sequencer.
package coffee_pkg;

  localparam logic [3:0] STEP_OFF = 4'd0;
  localparam logic [3:0] STEP_A   = 4'd1;
  localparam logic [3:0] STEP_C   = 4'd2;
  localparam logic [3:0] STEP_L   = 4'd3;
  localparam logic [3:0] STEP_U   = 4'd4;
  localparam logic [3:0] STEP_E   = 4'd5;
  localparam logic [3:0] STEP_FIN = 4'd6;

  localparam int N_STEP_KINDS = 5;

  // Step index returned when no enabled step remains.
  localparam logic [2:0] NO_STEP = 3'd5;

  // Bit/slot 0 is A (water) through 4 = E (cream); dur is in seconds.
  typedef struct packed {
    logic [N_STEP_KINDS-1:0]       mask;
    logic [N_STEP_KINDS-1:0][3:0]  dur;
  } recipe_t;

  localparam recipe_t RECIPE_AMERICANO = '{mask: 5'b00011,
                                           dur:  {4'd0, 4'd0, 4'd0, 4'd3, 4'd4}};
  localparam recipe_t RECIPE_LATTE     = '{mask: 5'b01110,
                                           dur:  {4'd0, 4'd2, 4'd4, 4'd3, 4'd0}};
  localparam recipe_t RECIPE_CAPPUCCINO = '{mask: 5'b10110,
                                            dur:  {4'd2, 4'd0, 4'd3, 4'd3, 4'd0}};
  localparam recipe_t RECIPE_EMPTY     = '{mask: 5'b00000, dur: '0};

  localparam recipe_t RECIPES [16] = '{
    RECIPE_AMERICANO, RECIPE_LATTE, RECIPE_CAPPUCCINO, RECIPE_EMPTY,
    RECIPE_EMPTY, RECIPE_EMPTY, RECIPE_EMPTY, RECIPE_EMPTY,
    RECIPE_EMPTY, RECIPE_EMPTY, RECIPE_EMPTY, RECIPE_EMPTY,
    RECIPE_EMPTY, RECIPE_EMPTY, RECIPE_EMPTY, RECIPE_EMPTY
  };

  // Lowest enabled step index at or after 'from', or NO_STEP.
  function automatic logic [2:0] first_enabled(recipe_t r, logic [2:0] from);
    logic [2:0] idx;
    idx = NO_STEP;
    for (int i = N_STEP_KINDS - 1; i >= 0; i--) begin
      if (i >= int'(from) && r.mask[i] && r.dur[i] != 4'd0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: one-cycle tick every TICK_DIV enabled cycles, synchronous clear.
module sec_tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick must not depend on clear: the sequencer derives clear from tick.
  assign tick = enable && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/coffee_recipe_sequencer.sv
// Multi-recipe coffee sequencer: recipe selection, timed dispense steps, done hold and cancel.
module coffee_recipe_sequencer
  import coffee_pkg::*;
#(
  parameter int unsigned N_RECIPES   = 3,
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned DONE_HOLD_S = 3,
  parameter int unsigned SEL_W       = $clog2(N_RECIPES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next_pulse,
  input  logic             select_pulse,
  input  logic             cancel_pulse,
  output logic [SEL_W-1:0] recipe_sel,
  output logic [3:0]       step_code,
  output logic [3:0]       secs_left,
  output logic             busy,
  output logic             done,
  output logic             done_pulse,
  output logic             aborted_pulse
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [SEL_W-1:0] SelLast  = SEL_W'(N_RECIPES - 1);
  localparam logic [3:0]       HoldSecs = 4'(DONE_HOLD_S);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       secs_q, secs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_pulse_q, done_pulse_d;
  logic             aborted_q, aborted_d;

  logic       tick;
  logic       tick_clear;
  logic       load;
  logic       go_idle;
  logic [2:0] nxt_idx;
  recipe_t    cur;

  assign cur = RECIPES[4'(sel_q)];

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (state_q != StIdle),
    .tick   (tick)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    idx_d        = idx_q;
    code_d       = code_q;
    secs_d       = secs_q;
    done_pulse_d = 1'b0;
    aborted_d    = 1'b0;
    tick_clear   = 1'b0;
    load         = 1'b0;
    go_idle      = 1'b0;
    nxt_idx      = first_enabled(cur, (state_q == StIdle) ? 3'd0 : idx_q + 3'd1);

    case (state_q)
      StIdle: begin
        if (select_pulse) begin
          load = 1'b1;
        end else if (next_pulse) begin
          sel_d = (sel_q == SelLast) ? '0 : sel_q + 1'b1;
        end
      end
      StRun: begin
        if (cancel_pulse) begin
          go_idle   = 1'b1;
          aborted_d = 1'b1;
        end else if (tick) begin
          if (secs_q == 4'd1) load = 1'b1;
          else                secs_d = secs_q - 4'd1;
        end
      end
      StDone: begin
        if (cancel_pulse) begin
          go_idle   = 1'b1;
          aborted_d = 1'b1;
        end else if (tick) begin
          if (secs_q == 4'd1) go_idle = 1'b1;
          else                secs_d = secs_q - 4'd1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    // Skipping happens here, so a disabled step never reaches the outputs.
    if (load) begin
      tick_clear = 1'b1;
      if (nxt_idx == NO_STEP) begin
        state_d      = StDone;
        code_d       = STEP_FIN;
        secs_d       = HoldSecs;
        done_pulse_d = 1'b1;
      end else begin
        state_d = StRun;
        idx_d   = nxt_idx;
        code_d  = STEP_A + {1'b0, nxt_idx};
        secs_d  = cur.dur[nxt_idx];
      end
    end

    if (go_idle) begin
      tick_clear = 1'b1;
      state_d    = StIdle;
      code_d     = STEP_OFF;
      secs_d     = 4'd0;
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      idx_q        <= 3'd0;
      code_q       <= STEP_OFF;
      secs_q       <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      code_q       <= code_d;
      secs_q       <= secs_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      aborted_q    <= aborted_d;
    end
  end

  assign recipe_sel    = sel_q;
  assign step_code     = code_q;
  assign secs_left     = secs_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign done_pulse    = done_pulse_q;
  assign aborted_pulse = aborted_q;

endmodule

// File: doc/coffee_recipe_sequencer.md
Name: coffee_recipe_sequencer

Overview:
Parametrised successor to the single-recipe coffee FSM. Holds a table of N_RECIPES recipes and lets the user cycle through them. Each recipe runs an ordered subset of five dispense steps with per-step durations in seconds, and the user can cancel a recipe mid-run. The block sits between the debounce/edge-detect front end and the display decoders and LED animation, on the single system clock; it contains no derived clocks.

Parameters:
N_RECIPES, 3, number of selectable recipes (2..16).
TICK_DIV, 50000000, clk cycles per one-second tick.
DONE_HOLD_S, 3, seconds the "F" (finished) code is held before returning to idle (1..15).
SEL_W, $clog2(N_RECIPES), width of recipe_sel (derived; do not override).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
next_pulse  in  1  one-cycle pulse, already debounced and edge-detected: advance recipe.
select_pulse  in  1  one-cycle pulse: start the selected recipe.
cancel_pulse  in  1  one-cycle pulse: abort a running or finished recipe.
recipe_sel  out  SEL_W  currently selected recipe index.
step_code  out  4  0 = off, 1 = A (water), 2 = C (coffee), 3 = L (milk), 4 = U (sugar), 5 = E (cream), 6 = F (finished).
secs_left  out  4  seconds remaining in the current step or in the done hold.
busy  out  1  high in RUN and DONE.
done  out  1  level, high throughout DONE (drives the LED animation).
done_pulse  out  1  one cycle on entry to DONE.
aborted_pulse  out  1  one cycle when a cancel is taken.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; all outputs 0; tick prescaler 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - next_pulse: recipe_sel increments; N_RECIPES-1 wraps to 0.
  - select_pulse: enter RUN at the first enabled step.
  - If next_pulse and select_pulse arrive together, select wins and recipe_sel is unchanged.
  - cancel_pulse is ignored.
- Step enable: a step is enabled when its mask bit is set and its duration is nonzero. Steps run in fixed order A, C, L, U, E. Disabled steps are skipped combinationally, so no cycle ever shows a disabled step.
- A recipe with no enabled steps goes from IDLE directly to DONE.
- Latency: select_pulse sampled at edge k gives step_code and secs_left = dur valid after edge k.
- RUN:
  - The prescaler clears on every step entry, so a step of duration D lasts exactly D*TICK_DIV cycles.
  - secs_left decrements on each tick.
  - A tick with secs_left = 1 loads the next enabled step. If no enabled step remains, the block enters DONE with step_code = 6 and secs_left = DONE_HOLD_S.
- next_pulse and select_pulse are ignored while busy; recipe_sel is frozen.
- cancel_pulse in RUN or DONE: next state IDLE, step_code = 0, secs_left = 0, aborted_pulse = 1. recipe_sel is retained. If cancel coincides with a step-expiry tick, cancel wins.
- DONE:
  - done = 1 for DONE_HOLD_S*TICK_DIV cycles, then IDLE.
  - done_pulse fires once on entry.
  - aborted_pulse is never asserted for normal completion.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge. After release, the block is in IDLE with recipe_sel = 0.

Decomposition:
- Package coffee_pkg holds:
  - step code constants STEP_OFF … STEP_FIN (0..6);
  - N_STEP_KINDS = 5;
  - recipe_t struct: mask[4:0] and dur[5][3:0] seconds;
  - RECIPES constant array, indexed 0..15.
- Default RECIPES entries:
  - 0 = Americano: A 4, C 3.
  - 1 = Latte: C 3, L 4, U 2.
  - 2 = Capuccino: C 3, L 3, E 2.
  - 3..15 = all-disabled.
- Sub-module sec_tick_gen: TICK_DIV prescaler with synchronous clear and enable, producing a one-cycle tick. It uses the same asynchronous active-low reset.

Test Plan:
(All scenarios use TICK_DIV = 4 and DONE_HOLD_S = 3.)
- Reset: hold reset = 0 for 3 cycles, then release → recipe_sel = 0, step_code = 0, busy = 0, done = 0, secs_left = 0; no pulses. Assert reset again mid-RUN → outputs go to 0 before the next clk edge.
- Recipe cycling: four next_pulse → recipe_sel 1, 2, 0, 1. next_pulse and select_pulse in the same cycle → RUN starts with recipe_sel unchanged. next_pulse during RUN → recipe_sel unchanged.
- Recipe 0 full run: select_pulse → step_code 1 for 16 cycles (secs_left 4, 3, 2, 1), then 2 for 12 cycles. Then 6 with done = 1 for 12 cycles and done_pulse exactly once, then step_code 0, busy 0.
- Skipping: recipe 1 → first step_code is 2 the cycle after select_pulse (A never appears). Sequence is 2 (12 cycles), 3 (16 cycles), 4 (8 cycles), then 6.
- Cancel: cancel_pulse 5 cycles into step C of recipe 2 → next cycle step_code 0, busy 0, aborted_pulse for 1 cycle, done_pulse never seen. Cancel coinciding with an expiry tick → IDLE, not the next step.
- Empty recipe: N_RECIPES = 4, select recipe 3 → DONE next cycle (step_code 6, done_pulse), IDLE after 12 cycles.
